branch_resolve: RTL and testbench
=================================

BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, datapath width of PC, offset and target.
REQ-002 SHALL provide parameter FLUSH_CYCLES, default 2, number of cycles flush is held after a mispredict (legal 1..15).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  branch operands and comparator flags valid this cycle.
REQ-007 in_ready  output  1  stage can accept; transfer occurs when in_valid & in_ready.
REQ-008 br_op  input  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BLE, 110 BGT, 111 J.
REQ-009 lt, eq, gt  input  1 each  flags from the upstream comparator (signedness already applied there).
REQ-010 pred_taken  input  1  fetch-stage prediction for this branch.
REQ-011 pc_plus4  input  WIDTH  address of the following instruction.
REQ-012 offset  input  WIDTH  sign-extended word offset (not yet shifted).
REQ-013 out_valid, taken  output  1 each  resolved result valid and its direction.
REQ-014 target  output  WIDTH  computed branch target.
REQ-015 redirect_valid  output  1  one-cycle fetch redirect pulse.
REQ-016 redirect_pc  output  WIDTH  correct fetch address on redirect.
REQ-017 flush  output  1  kill younger in-flight instructions.
REQ-018 mispredict_cnt  output  16  saturating mispredict count.

Function
REQ-019 Condition: BEQ=eq, BNE=!eq, BLT=lt, BGE=!lt, BLE=lt|eq, BGT=gt, J=1, none=0.
REQ-020 target SHALL be pc_plus4 + (offset << 2), modulo 2^WIDTH, wrap-around silent.
REQ-021 Latency one cycle: a transfer on edge N SHALL produce out_valid=1 for exactly the cycle after edge N, with taken/target registered from the transfer.
REQ-022 out_valid SHALL be 0 in every cycle without a preceding transfer; taken/target hold last value.
REQ-023 Mispredict SHALL be (taken != pred_taken) and br_op != 000; br_op=000 never mispredicts.
REQ-024 On mispredict, redirect_valid SHALL be 1 in the out_valid cycle only; redirect_pc = target if taken else pc_plus4.
REQ-025 FSM states IDLE and FLUSH; IDLE->FLUSH on a transfer that mispredicts; otherwise stay IDLE.
REQ-026 FLUSH: flush=1 and in_ready=0 for exactly FLUSH_CYCLES cycles starting with the redirect cycle, counted by a down-counter; FLUSH->IDLE when the counter reaches 1.
REQ-027 in_ready SHALL be 1 exactly when state is IDLE (combinational from state); back-to-back correctly predicted transfers SHALL be accepted every cycle.
REQ-028 in_valid while in FLUSH SHALL be ignored; no output or state change results.
REQ-029 mispredict_cnt SHALL increment by 1 on each mispredicting transfer and hold at 16'hFFFF.
REQ-030 Flags not selected by br_op SHALL not affect any output.

Reset
REQ-031 rst_n low SHALL immediately set state IDLE, counter 0, out_valid, taken, redirect_valid, flush = 0, target, redirect_pc = 0, mispredict_cnt = 0.
REQ-032 Reset asserted mid-FLUSH SHALL abort the flush immediately; first cycle after release in_ready=1.

Verification
REQ-033 BEQ, eq=1, pred_taken=1, pc_plus4=0x100, offset=0x4 -> next cycle out_valid=1, taken=1, target=0x110, no redirect, flush=0.
REQ-034 BNE, eq=1, pred_taken=1, pc_plus4=0x200 -> taken=0, redirect_valid=1, redirect_pc=0x200, flush=1 two cycles, in_ready=0 two cycles, mispredict_cnt=1.
REQ-035 BLT lt=1, pred_taken=0, pc_plus4=0x10, offset=0xFFFFFFFC -> target=0x0, redirect_pc=0x0; in_valid pulsed during flush is dropped.
REQ-036 Correct predictions on five consecutive cycles -> in_ready stays 1, five out_valid pulses in order.
REQ-037 pc_plus4=0xFFFFFFFC, offset=0x1, J -> target=0x0 (wrap).
REQ-038 rst_n low in second flush cycle -> flush, redirect_valid, mispredict_cnt = 0 immediately; in_ready=1 after release.

Source files
------------

// File: rtl/branch_resolve.sv
// branch_resolve: one-cycle branch resolution with mispredict redirect and timed flush
module branch_resolve #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       br_op,
  input  logic             lt,
  input  logic             eq,
  input  logic             gt,
  input  logic             pred_taken,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] offset,
  output logic             out_valid,
  output logic             taken,
  output logic [WIDTH-1:0] target,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             flush,
  output logic [15:0]      mispredict_cnt
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [3:0] FC    = 4'(FLUSH_CYCLES);
  logic [0:0]       state;
  logic [3:0]       cnt;
  logic             cond, xfer, mp;
  logic [WIDTH-1:0] tgt;
  always_comb begin
    cond = br_op == 3'd1 ? eq :
           br_op == 3'd2 ? !eq :
           br_op == 3'd3 ? lt :
           br_op == 3'd4 ? !lt :
           br_op == 3'd5 ? (lt | eq) :
           br_op == 3'd6 ? gt :
           br_op == 3'd7;
    in_ready = state == IDLE;
    flush    = state == FLUSH;
    xfer     = in_valid & in_ready;
    mp       = xfer & (br_op != 3'd0) & (cond != pred_taken);
    tgt      = pc_plus4 + (offset << 2);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      out_valid      <= 1'b0;
      taken          <= 1'b0;
      target         <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      mispredict_cnt <= '0;
    end else begin
      out_valid      <= xfer;
      redirect_valid <= mp;
      if (xfer) begin
        taken  <= cond;
        target <= tgt;
      end
      // no transfer can happen in FLUSH, so mp and the countdown are exclusive
      if (mp) begin
        redirect_pc    <= cond ? tgt : pc_plus4;
        state          <= FLUSH;
        cnt            <= FC;
        mispredict_cnt <= mispredict_cnt + {15'd0, mispredict_cnt != 16'hFFFF};
      end else if (state == FLUSH) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) state <= IDLE;
      end
    end
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: vector table, directed corner sequences and random run against a reference model
module tb_branch_resolve;
  localparam int FC = 2;
  logic        clk = 0, rst_n = 0, in_valid = 0, lt = 0, eq = 0, gt = 0, pred_taken = 0;
  logic [2:0]  br_op = 0;
  logic [31:0] pc_plus4 = 0, offset = 0;
  logic        in_ready, out_valid, taken, redirect_valid, flush;
  logic [31:0] target, redirect_pc;
  logic [15:0] mispredict_cnt;
  int errors = 0, checks = 0;
  int m_left, m_cnt;
  logic m_ov, m_tk, m_rv;
  logic [31:0] m_tgt, m_rpc;

  branch_resolve #(.WIDTH(32), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .br_op(br_op),
    .lt(lt), .eq(eq), .gt(gt), .pred_taken(pred_taken), .pc_plus4(pc_plus4), .offset(offset),
    .out_valid(out_valid), .taken(taken), .target(target), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .mispredict_cnt(mispredict_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op; logic lt, eq, gt, pred; logic [31:0] pc, off;
    logic e_tk; logic [31:0] e_tgt; logic e_red; logic [31:0] e_rpc;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic f_cond(input logic [2:0] op, input logic l, input logic e, input logic g);
    case (op)
      3'd1: return e;
      3'd2: return !e;
      3'd3: return l;
      3'd4: return !l;
      3'd5: return l || e;
      3'd6: return g;
      3'd7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_all();
    chk("in_ready", in_ready, m_left == 0);
    chk("flush", flush, m_left > 0);
    chk("out_valid", out_valid, m_ov);
    chk("taken", taken, m_tk);
    chk("target", target, m_tgt);
    chk("redirect_valid", redirect_valid, m_rv);
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("mispredict_cnt", mispredict_cnt, 64'(m_cnt));
  endtask

  task automatic step();
    logic x, c, mp;
    logic [31:0] t, p;
    x = in_valid && m_left == 0;
    c = f_cond(br_op, lt, eq, gt);
    t = pc_plus4 + offset * 32'd4;
    p = pc_plus4;
    mp = x && br_op != 3'd0 && c != pred_taken;
    @(posedge clk); #1;
    m_ov = x;
    m_rv = mp;
    if (x) begin m_tk = c; m_tgt = t; end
    if (mp) begin
      m_rpc = c ? t : p;
      if (m_cnt < 65535) m_cnt++;
      m_left = FC;
    end else if (m_left > 0) m_left--;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    m_left = 0; m_cnt = 0; m_ov = 0; m_tk = 0; m_rv = 0; m_tgt = 0; m_rpc = 0;
    check_all();
    #2 rst_n = 1;
  endtask

  task automatic drive(input logic [2:0] op, input logic l, input logic e, input logic g,
                       input logic p, input logic [31:0] pc, input logic [31:0] off);
    in_valid = 1; br_op = op; lt = l; eq = e; gt = g; pred_taken = p; pc_plus4 = pc; offset = off;
  endtask

  initial begin
    vt[0] = '{3'd1, 0, 1, 0, 1, 32'h100, 32'h4, 1, 32'h110, 0, 32'h0};
    vt[1] = '{3'd2, 0, 1, 0, 1, 32'h200, 32'h8, 0, 32'h220, 1, 32'h200};
    vt[2] = '{3'd3, 1, 0, 0, 0, 32'h10, 32'hFFFFFFFC, 1, 32'h0, 1, 32'h0};
    vt[3] = '{3'd7, 0, 0, 0, 1, 32'hFFFFFFFC, 32'h1, 1, 32'h0, 0, 32'h0};
    vt[4] = '{3'd4, 1, 0, 1, 0, 32'h40, 32'h2, 0, 32'h48, 0, 32'h0};
    vt[5] = '{3'd5, 0, 1, 0, 0, 32'h80, 32'h10, 1, 32'hC0, 1, 32'hC0};
    vt[6] = '{3'd6, 1, 0, 0, 1, 32'h300, 32'h1, 0, 32'h304, 1, 32'h300};
    vt[7] = '{3'd0, 0, 1, 0, 1, 32'h50, 32'h1, 0, 32'h54, 0, 32'h0};
    #2;
    do_reset();
    step();
    foreach (vt[i]) begin
      int n;
      drive(vt[i].op, vt[i].lt, vt[i].eq, vt[i].gt, vt[i].pred, vt[i].pc, vt[i].off);
      step();
      chk($sformatf("v%0d out_valid", i), out_valid, 1);
      chk($sformatf("v%0d taken", i), taken, vt[i].e_tk);
      chk($sformatf("v%0d target", i), target, vt[i].e_tgt);
      chk($sformatf("v%0d redirect", i), redirect_valid, vt[i].e_red);
      if (vt[i].e_red) chk($sformatf("v%0d redirect_pc", i), redirect_pc, vt[i].e_rpc);
      // keep in_valid high through the flush so the dropped requests get exercised
      drive(3'd1, 0, 1, 0, 0, 32'hDEAD0, 32'h1);
      n = 0;
      while (flush && n < 20) begin
        n++;
        chk($sformatf("v%0d in_ready in flush", i), in_ready, 0);
        step();
        chk($sformatf("v%0d dropped", i), out_valid, 0);
      end
      chk($sformatf("v%0d flush cycles", i), n, vt[i].e_red ? FC : 0);
      in_valid = 0;
      step();
    end
    for (int i = 0; i < 5; i++) begin
      drive(3'd7, 0, 0, 0, 1, 32'h1000 + 32'(16 * i), 32'(i));
      step();
      chk($sformatf("b2b%0d out_valid", i), out_valid, 1);
      chk($sformatf("b2b%0d target", i), target, 32'h1000 + 32'(20 * i));
      chk($sformatf("b2b%0d in_ready", i), in_ready, 1);
    end
    in_valid = 0;
    step();
    drive(3'd2, 0, 1, 0, 1, 32'h200, 32'h0);
    step();
    in_valid = 0;
    step();
    chk("midflush flush", flush, 1);
    do_reset();
    chk("reset redirect", redirect_valid, 0);
    chk("reset cnt", mispredict_cnt, 0);
    step();
    chk("post reset in_ready", in_ready, 1);
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom_range(7)), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, $urandom);
      in_valid = 1'($urandom_range(3) != 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
